// File: rtl/fft_pkg.sv
// Shared constants, frame-length helper and state encodings for the FFT
// output frame collector.
package fft_pkg;

  localparam int unsigned FFT_DW      = 16;
  localparam int unsigned FFT_NMAX_LG = 9;

  typedef enum logic [1:0] {
    NP_64  = 2'd0,
    NP_128 = 2'd1,
    NP_256 = 2'd2,
    NP_512 = 2'd3
  } np_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FILL,
    WR_DROP
  } wr_state_e;

  function automatic int unsigned frame_len(input logic [1:0] np);
    return 32'd64 << np;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// Ping-pong sample store: simple dual-port RAM, sync write, registered read.
// Address MSB selects the bank.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int unsigned DW = FFT_DW,
  parameter int unsigned AW = FFT_NMAX_LG
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW:0]     waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic            re,
  input  logic [AW:0]     raddr,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_collector.sv
// Collects FFT output frames into a two-bank buffer, checks framing and replays
// each frame on a valid/ready stream with sop/eop/index.
module fft_frame_collector
  import fft_pkg::*;
#(
  parameter int unsigned DW      = FFT_DW,
  parameter int unsigned NMAX_LG = FFT_NMAX_LG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         np,
  input  logic               valid_in,
  input  logic               sop_in,
  input  logic [DW-1:0]      d_re,
  input  logic [DW-1:0]      d_im,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_sop,
  output logic               m_eop,
  output logic [NMAX_LG-1:0] m_idx,
  output logic [DW-1:0]      m_re,
  output logic [DW-1:0]      m_im,
  output logic               frame_err,
  output logic               overflow
);

  typedef logic [NMAX_LG-1:0] idx_t;

  wr_state_e wstate, wstate_nx;
  logic      wr_bank, wr_bank_nx;
  idx_t      wr_idx, wr_idx_nx, wr_last, wr_last_nx, wr_addr, np_last;
  logic      we, fill_done, err_nx, ovf_nx, bank_free;

  logic [1:0] full;
  idx_t       bank_last [2];
  logic       rd_bank, iss_bank, re, r_vld, r_sop, r_eop, r_move, eop_xfer;
  idx_t       iss_idx, r_idx;
  logic [2*DW-1:0] rdata;

  assign np_last  = idx_t'(frame_len(np) - 1);
  assign eop_xfer = m_valid & m_ready & m_eop;
  // A bank released by this cycle's eop transfer is already usable by a sop.
  assign bank_free = !full[wr_bank] || (eop_xfer && (rd_bank == wr_bank));

  always_comb begin
    wstate_nx  = wstate;
    wr_bank_nx = wr_bank;
    wr_idx_nx  = wr_idx;
    wr_last_nx = wr_last;
    wr_addr    = '0;
    we         = 1'b0;
    fill_done  = 1'b0;
    err_nx     = 1'b0;
    ovf_nx     = 1'b0;
    if (valid_in) begin
      if (sop_in) begin
        if (wstate == WR_FILL) err_nx = 1'b1;
        if (wstate == WR_FILL || bank_free) begin
          we         = 1'b1;
          wr_idx_nx  = '0;
          wr_last_nx = np_last;
          wstate_nx  = WR_FILL;
        end else begin
          ovf_nx    = 1'b1;
          wstate_nx = WR_DROP;
        end
      end else if (wstate == WR_FILL) begin
        we        = 1'b1;
        wr_addr   = wr_idx + 1'b1;
        wr_idx_nx = wr_addr;
        if (wr_addr == wr_last) begin
          fill_done  = 1'b1;
          wr_bank_nx = ~wr_bank;
          wstate_nx  = WR_IDLE;
        end
      end else if (wstate == WR_IDLE) begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate    <= WR_IDLE;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      wr_last   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      wstate    <= wstate_nx;
      wr_bank   <= wr_bank_nx;
      wr_idx    <= wr_idx_nx;
      wr_last   <= wr_last_nx;
      frame_err <= err_nx;
      overflow  <= ovf_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full         <= '0;
      bank_last[0] <= '0;
      bank_last[1] <= '0;
      rd_bank      <= 1'b0;
    end else begin
      if (eop_xfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (fill_done) begin
        full[wr_bank]      <= 1'b1;
        bank_last[wr_bank] <= wr_last;
      end
    end
  end

  // Two-stage read pipe: RAM output stage (r_*) feeds the output register.
  // A read is issued only when the RAM stage is empty or drains this cycle,
  // so no sample is lost under back-pressure and streaming is 1/cycle.
  assign r_move = r_vld && (!m_valid || m_ready);
  assign re     = full[iss_bank] && (!r_vld || r_move);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_bank <= 1'b0;
      iss_idx  <= '0;
      r_vld    <= 1'b0;
      r_idx    <= '0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
    end else begin
      if (re) begin
        r_idx <= iss_idx;
        r_sop <= (iss_idx == '0);
        r_eop <= (iss_idx == bank_last[iss_bank]);
        if (iss_idx == bank_last[iss_bank]) begin
          iss_idx  <= '0;
          iss_bank <= ~iss_bank;
        end else begin
          iss_idx <= iss_idx + 1'b1;
        end
      end
      if (re)          r_vld <= 1'b1;
      else if (r_move) r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_idx   <= '0;
      m_re    <= '0;
      m_im    <= '0;
    end else if (r_move) begin
      m_valid <= 1'b1;
      m_sop   <= r_sop;
      m_eop   <= r_eop;
      m_idx   <= r_idx;
      m_re    <= rdata[2*DW-1:DW];
      m_im    <= rdata[DW-1:0];
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  fft_frame_bank #(.DW(DW), .AW(NMAX_LG)) u_bank (
    .clk   (clk),
    .we    (we),
    .waddr ({wr_bank, wr_addr}),
    .wdata ({d_re, d_im}),
    .re    (re),
    .raddr ({iss_bank, iss_idx}),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector: random frames against a
// queue-based framing/occupancy model.
module tb_fft_frame_collector;

  localparam int DW = 16;
  localparam int NL = 9;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [1:0]    np = '0;
  logic          valid_in = 1'b0, sop_in = 1'b0;
  logic [DW-1:0] d_re = '0, d_im = '0;
  logic          m_valid, m_ready = 1'b0, m_sop, m_eop;
  logic [NL-1:0] m_idx;
  logic [DW-1:0] m_re, m_im;
  logic          frame_err, overflow;

  fft_frame_collector #(.DW(DW), .NMAX_LG(NL)) dut (
    .clk(clk), .rst_n(rst_n), .np(np), .valid_in(valid_in), .sop_in(sop_in),
    .d_re(d_re), .d_im(d_im), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .m_idx(m_idx), .m_re(m_re), .m_im(m_im),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [NL-1:0] idx;
    logic          sop;
    logic          eop;
  } smp_t;

  smp_t exp_q[$], cap_q[$], cur[$];
  int   cap_cyc[$], frame_ends[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, last_in_cyc = 0, first_valid_cyc = -1;
  int   cap_total = 0, exp_total = 0, cur_len = 0;
  int   err_seen = 0, ovf_seen = 0, err_exp = 0, ovf_exp = 0, stall_viol = 0;
  int   ready_mode = 0;
  bit   in_frame = 0, dropping = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output observer: records transfers, pulse counts and stall stability.
  initial begin : monitor
    smp_t prev, now_s;
    bit   prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        now_s = {m_re, m_im, m_idx, m_sop, m_eop};
        if (prev_stall && (!m_valid || now_s !== prev)) stall_viol++;
        prev_stall = m_valid && !m_ready;
        prev = now_s;
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
          cap_q.push_back(now_s);
          cap_cyc.push_back(cyc);
          cap_total++;
        end
        if (frame_err) err_seen++;
        if (overflow)  ovf_seen++;
      end
    end
  end

  // Reference model: frames are assembled from sop-delimited samples; a new
  // frame is accepted only while fewer than two completed frames are unread.
  task automatic model_in(input bit s, input logic [1:0] n, input logic [DW-1:0] re, input logic [DW-1:0] im);
    int   pend;
    smp_t e;
    pend = 0;
    foreach (frame_ends[i]) if (frame_ends[i] > cap_total) pend++;
    e = {re, im, NL'(0), 1'b0, 1'b0};
    if (s) begin
      if (in_frame) begin
        err_exp++;
        cur.delete(); cur.push_back(e); cur_len = 64 << n;
      end else if (pend >= 2) begin
        ovf_exp++;
        dropping = 1;
      end else begin
        in_frame = 1; dropping = 0;
        cur.delete(); cur.push_back(e); cur_len = 64 << n;
      end
    end else if (in_frame) begin
      cur.push_back(e);
    end else if (!dropping) begin
      err_exp++;
    end
    if (in_frame && cur.size() == cur_len) begin
      foreach (cur[i]) begin
        e = cur[i];
        e.idx = NL'(i);
        e.sop = (i == 0);
        e.eop = (i == cur_len - 1);
        exp_q.push_back(e);
      end
      exp_total += cur_len;
      frame_ends.push_back(exp_total);
      in_frame = 0;
      cur.delete();
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); cap_q.delete(); cap_cyc.delete(); frame_ends.delete();
    cap_total = 0; exp_total = 0;
    err_seen = 0; ovf_seen = 0; err_exp = 0; ovf_exp = 0; stall_viol = 0;
  endtask

  task automatic drive(input bit v, input bit s, input logic [1:0] n, input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(posedge clk); #1;
    valid_in = v; sop_in = s; np = n; d_re = re; d_im = im;
    if (v) begin
      last_in_cyc = cyc;
      model_in(s, n, re, im);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, np, '0, '0);
  endtask

  // np is randomised on non-sop samples: it must only matter at sop.
  task automatic send_frame(input logic [1:0] n, input int len, input int gap_pct, input bit ramp);
    for (int i = 0; i < len; i++) begin
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
        drive(1'b0, 1'b0, 2'($urandom), '0, '0);
      drive(1'b1, i == 0, (i == 0) ? n : 2'($urandom),
            ramp ? DW'(i) : DW'($urandom), ramp ? DW'(-i) : DW'($urandom));
    end
  endtask

  task automatic wait_out(input int n, input int budget);
    for (int k = 0; k < budget && cap_q.size() < n; k++) @(posedge clk);
    repeat (8) @(posedge clk);
  endtask

  function automatic int stream_diff();
    int n;
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ready_mode = 1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    n_checks++; if ({m_sop, m_eop, m_idx, m_re, m_im} !== '0) begin n_fail++; $display("FAIL reset_data: got sop=%b eop=%b idx=%0d re=%h im=%h expected all 0", m_sop, m_eop, m_idx, m_re, m_im); end
    n_checks++; if ({frame_err, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got err=%b ovf=%b expected 0", frame_err, overflow); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got m_valid=%b expected 0", m_valid); end
  endtask

  task automatic test_single_frame();
    int d;
    model_clear(); ready_mode = 1; first_valid_cyc = -1;
    send_frame(2'd3, 512, 0, 1'b1);
    idle();
    wait_out(512, 2000);
    n_checks++; if (first_valid_cyc !== last_in_cyc + 3) begin n_fail++; $display("FAIL first_valid_latency: got cycle %0d expected %0d", first_valid_cyc, last_in_cyc + 3); end
    n_checks++; if (cap_q.size() !== 512) begin n_fail++; $display("FAIL single_count: got %0d expected 512", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL single_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (cap_q.size() < 512 || cap_q[0].sop !== 1'b1 || cap_q[511].eop !== 1'b1 || cap_q[511].idx !== 9'd511) begin n_fail++; $display("FAIL single_sop_eop: got size=%0d expected sop@0 eop@511", cap_q.size()); end
    n_checks++; if (err_seen !== 0) begin n_fail++; $display("FAIL single_no_err: got %0d expected 0", err_seen); end
  endtask

  task automatic test_back_to_back();
    int d;
    model_clear(); ready_mode = 2;
    send_frame(2'd3, 512, 0, 1'b0);
    send_frame(2'd3, 512, 0, 1'b0);
    idle();
    wait_out(1024, 8000);
    n_checks++; if (cap_q.size() !== 1024) begin n_fail++; $display("FAIL b2b_count: got %0d expected 1024", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL b2b_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL b2b_stall_stable: got %0d violations expected 0", stall_viol); end
    n_checks++; if (err_seen !== 0 || ovf_seen !== 0) begin n_fail++; $display("FAIL b2b_pulses: got err=%0d ovf=%0d expected 0", err_seen, ovf_seen); end

    model_clear(); ready_mode = 1;
    send_frame(2'd3, 512, 0, 1'b0);
    send_frame(2'd0, 64, 0, 1'b0);
    idle();
    wait_out(576, 3000);
    n_checks++; if (cap_q.size() !== 576) begin n_fail++; $display("FAIL b2b_full_count: got %0d expected 576", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL b2b_full_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (cap_cyc.size() < 513 || cap_cyc[512] - cap_cyc[511] !== 1) begin n_fail++; $display("FAIL b2b_no_bubble: got gap %0d expected 1", (cap_cyc.size() < 513) ? -1 : cap_cyc[512] - cap_cyc[511]); end
  endtask

  task automatic test_restart();
    int d;
    model_clear(); ready_mode = 1;
    send_frame(2'd3, 100, 0, 1'b0);
    send_frame(2'd3, 512, 15, 1'b0);
    idle();
    wait_out(512, 3000);
    n_checks++; if (err_seen !== err_exp) begin n_fail++; $display("FAIL restart_err: got %0d pulses expected %0d", err_seen, err_exp); end
    n_checks++; if (cap_q.size() !== 512) begin n_fail++; $display("FAIL restart_count: got %0d expected 512", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL restart_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
  endtask

  task automatic test_overflow();
    int d;
    model_clear(); ready_mode = 0;
    repeat (3) send_frame(2'd0, 64, 10, 1'b0);
    idle();
    repeat (10) @(posedge clk);
    n_checks++; if (ovf_seen !== ovf_exp || ovf_seen !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d expected %0d", ovf_seen, ovf_exp); end
    n_checks++; if (err_seen !== 0) begin n_fail++; $display("FAIL ovf_no_err: got %0d expected 0", err_seen); end
    n_checks++; if (cap_q.size() !== 0) begin n_fail++; $display("FAIL ovf_stalled: got %0d outputs expected 0", cap_q.size()); end
    ready_mode = 1;
    wait_out(128, 1000);
    repeat (20) @(posedge clk);
    n_checks++; if (cap_q.size() !== 128) begin n_fail++; $display("FAIL ovf_count: got %0d expected 128", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL ovf_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
  endtask

  task automatic test_lengths();
    int d;
    model_clear(); ready_mode = 1;
    send_frame(2'd0, 64, 20, 1'b0);
    send_frame(2'd2, 256, 20, 1'b0);
    idle();
    wait_out(320, 3000);
    n_checks++; if (cap_q.size() !== 320) begin n_fail++; $display("FAIL len_count: got %0d expected 320", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL len_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
    n_checks++; if (cap_q.size() < 320 || cap_q[63].eop !== 1'b1 || cap_q[63].idx !== 9'd63) begin n_fail++; $display("FAIL len_eop64: got size=%0d expected eop at idx 63", cap_q.size()); end
    n_checks++; if (cap_q.size() < 320 || cap_q[319].eop !== 1'b1 || cap_q[319].idx !== 9'd255) begin n_fail++; $display("FAIL len_eop256: got size=%0d expected eop at idx 255", cap_q.size()); end

    model_clear();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 2'($urandom), DW'($urandom), DW'($urandom));
    idle();
    repeat (20) @(posedge clk);
    n_checks++; if (err_seen !== err_exp || err_seen !== 5) begin n_fail++; $display("FAIL nosop_err: got %0d pulses expected %0d", err_seen, err_exp); end
    n_checks++; if (cap_q.size() !== 0) begin n_fail++; $display("FAIL nosop_output: got %0d outputs expected 0", cap_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d, k;
    model_clear(); ready_mode = 1;
    send_frame(2'd3, 512, 0, 1'b0);
    idle();
    for (k = 0; k < 3000 && !(m_valid === 1'b1 && m_idx === 9'd200); k++) @(negedge clk);
    n_checks++; if (m_idx !== 9'd200) begin n_fail++; $display("FAIL midreset_reach: got idx %0d expected 200", m_idx); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || m_idx !== '0) begin n_fail++; $display("FAIL midreset_async: got valid=%b idx=%0d expected 0", m_valid, m_idx); end
    in_frame = 0; dropping = 0; cur.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    send_frame(2'd0, 64, 0, 1'b0);
    idle();
    wait_out(64, 1000);
    n_checks++; if (cap_q.size() !== 64) begin n_fail++; $display("FAIL midreset_count: got %0d expected 64", cap_q.size()); end
    d = stream_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL midreset_data: first mismatch at %0d got %h expected %h", d, cap_q[d], exp_q[d]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_restart();
    test_overflow();
    test_lengths();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
